// File: rtl/lcd_char_driver_if.sv
// LCD parallel bus bundle (HD44780-style, 8-bit, write only).
//   lcd_e    : enable strobe
//   lcd_rs   : 0 = command, 1 = data
//   lcd_rw   : read/write select (driver holds it at 0)
//   lcd_data : 8-bit data bus
// master = the driver side, slave = the panel / observer side.
interface lcd_char_driver_if;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;

  modport master (output lcd_e, lcd_rs, lcd_rw, lcd_data);
  modport slave  (input  lcd_e, lcd_rs, lcd_rw, lcd_data);
endinterface

// File: rtl/lcd_char_driver.sv
// lcd_char_driver: drives a 16x2 HD44780-compatible LCD from two 128-bit
// ASCII line buffers. Waits POWERUP_CYC after reset, issues the init
// commands (0x38, 0x0C, 0x06, 0x01), then rewrites both rows forever from a
// snapshot of line1/line2 taken at the start of every refresh.
//
// Ports:
//   clk          : system clock
//   rst          : asynchronous reset, active low
//   line1/line2  : row text, char 0 in [127:120], char 15 in [7:0]
//   lcd          : LCD bus (lcd_char_driver_if.master)
//   ready        : high once the init sequence has completed
//   refresh_done : one-cycle pulse after the last char of row 2 finishes
//
// Optional build macro LCD_SKIP_UNCHANGED_EN: once one refresh has completed,
// identical snapshots are skipped (FSM idles in S_SNAP, re-sampling).
module lcd_char_driver #(
  parameter int POWERUP_CYC = 750000,
  parameter int SETUP_CYC   = 2,
  parameter int E_CYC       = 12,
  parameter int EXEC_CYC    = 2500,
  parameter int CLEAR_CYC   = 100000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [127:0]              line1,
  input  logic [127:0]              line2,
  lcd_char_driver_if.master         lcd,
  output logic                      ready,
  output logic                      refresh_done
);
  // Full transaction lengths: setup + strobe + post-strobe wait.
  localparam int T_EXE = SETUP_CYC + E_CYC + EXEC_CYC;
  localparam int T_CLR = SETUP_CYC + E_CYC + CLEAR_CYC;
  localparam int M1    = (POWERUP_CYC > T_CLR) ? POWERUP_CYC : T_CLR;
  localparam int MAXV  = (M1 > T_EXE) ? M1 : T_EXE;
  localparam int CW    = $clog2(MAXV + 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_SNAP, S_ADDR1, S_ROW1, S_ADDR2, S_ROW2, S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt, cnt_nxt, tx_last;
  logic [3:0]      idx;
  logic [127:0]    snap1, snap2;
  logic            e_on, tx_done, skip;

  function automatic logic [7:0] char_at(input logic [127:0] l, input logic [3:0] i);
    return l[{~i, 3'b000} +: 8];  // 8*(15-i)
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  // cnt is 0 on the cycle rs/data are loaded; the strobe spans the E_CYC
  // cycles right after the SETUP_CYC setup cycles.
  assign cnt_nxt = cnt + CW'(1);
  assign e_on    = (cnt_nxt >= CW'(SETUP_CYC)) && (cnt_nxt < CW'(SETUP_CYC + E_CYC));
  assign tx_last = (!lcd.lcd_rs && lcd.lcd_data == 8'h01) ? CW'(T_CLR - 1) : CW'(T_EXE - 1);
  assign tx_done = (cnt == tx_last);
  assign lcd.lcd_rw = 1'b0;

`ifdef LCD_SKIP_UNCHANGED_EN
  logic have_ref;  // at least one refresh has completed since init
  assign skip = have_ref && (line1 == snap1) && (line2 == snap2);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_PWRUP;
      cnt          <= '0;
      idx          <= '0;
      snap1        <= '0;
      snap2        <= '0;
      lcd.lcd_e    <= 1'b0;
      lcd.lcd_rs   <= 1'b0;
      lcd.lcd_data <= 8'h00;
      ready        <= 1'b0;
      refresh_done <= 1'b0;
`ifdef LCD_SKIP_UNCHANGED_EN
      have_ref     <= 1'b0;
`endif
    end else begin
      refresh_done <= 1'b0;
      case (state)
        S_PWRUP: begin
          if (cnt == CW'(POWERUP_CYC - 1)) begin
            cnt          <= '0;
            idx          <= '0;
            lcd.lcd_rs   <= 1'b0;
            lcd.lcd_data <= init_cmd(2'd0);
            state        <= S_INIT;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        S_SNAP: begin
          if (!skip) begin
            snap1        <= line1;
            snap2        <= line2;
            cnt          <= '0;
            lcd.lcd_rs   <= 1'b0;
            lcd.lcd_data <= 8'h80;
            state        <= S_ADDR1;
          end
        end
        S_DONE: begin
`ifdef LCD_SKIP_UNCHANGED_EN
          have_ref <= 1'b1;
`endif
          state <= S_SNAP;
        end
        default: begin  // bus transaction states
          if (!tx_done) begin
            cnt       <= cnt_nxt;
            lcd.lcd_e <= e_on;
          end else begin
            lcd.lcd_e <= 1'b0;
            cnt       <= '0;
            case (state)
              S_INIT: begin
                if (idx == 4'd3) begin
                  ready <= 1'b1;
                  state <= S_SNAP;
                end else begin
                  idx          <= idx + 4'd1;
                  lcd.lcd_rs   <= 1'b0;
                  lcd.lcd_data <= init_cmd(idx[1:0] + 2'd1);
                end
              end
              S_ADDR1: begin
                idx          <= '0;
                lcd.lcd_rs   <= 1'b1;
                lcd.lcd_data <= char_at(snap1, 4'd0);
                state        <= S_ROW1;
              end
              S_ROW1: begin
                // index 15 hands over to the address command; no wrap
                if (idx == 4'd15) begin
                  lcd.lcd_rs   <= 1'b0;
                  lcd.lcd_data <= 8'hC0;
                  state        <= S_ADDR2;
                end else begin
                  idx          <= idx + 4'd1;
                  lcd.lcd_data <= char_at(snap1, idx + 4'd1);
                end
              end
              S_ADDR2: begin
                idx          <= '0;
                lcd.lcd_rs   <= 1'b1;
                lcd.lcd_data <= char_at(snap2, 4'd0);
                state        <= S_ROW2;
              end
              default: begin  // S_ROW2
                if (idx == 4'd15) begin
                  refresh_done <= 1'b1;
                  state        <= S_DONE;
                end else begin
                  idx          <= idx + 4'd1;
                  lcd.lcd_data <= char_at(snap2, idx + 4'd1);
                end
              end
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_char_driver.sv
// Directed bench for lcd_char_driver with short timing parameters.
// A negedge monitor logs every lcd_e rise (cycle, rs, data) and checks strobe
// width, bus stability and lcd_rw; the main sequence pops those events and
// compares them with hand-derived values.
module tb_lcd_char_driver;
  localparam int PW = 20, SU = 1, EC = 2, EX = 3, CL = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] line1, line2;
  logic         ready, refresh_done;
  int           cyc = 0;
  int           n_chk = 0, n_fail = 0, rd_cnt = 0;

  lcd_char_driver_if lcd ();

  lcd_char_driver #(
    .POWERUP_CYC(PW), .SETUP_CYC(SU), .E_CYC(EC), .EXEC_CYC(EX), .CLEAR_CYC(CL)
  ) dut (
    .clk(clk), .rst(rst), .line1(line1), .line2(line2),
    .lcd(lcd), .ready(ready), .refresh_done(refresh_done)
  );

  always #5 clk = ~clk;

  // cycle number = posedges since reset release
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       rs;
    logic [7:0] data;
  } ev_t;
  ev_t evq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ch(input logic [127:0] l, input int i);
    return l[8*(15-i) +: 8];
  endfunction

  // bus monitor
  logic       pe = 1'b0, prs = 1'b0;
  logic [7:0] pd = 8'h00;
  int         elen = 0;
  always @(negedge clk) begin
    chk("rw_zero", {31'd0, lcd.lcd_rw}, 32'd0);
    if (!rst) begin
      pe   <= 1'b0;
      elen <= 0;
    end else begin
      if (lcd.lcd_e) begin
        chk("stable_rs", {31'd0, lcd.lcd_rs}, {31'd0, prs});
        chk("stable_data", {24'd0, lcd.lcd_data}, {24'd0, pd});
        if (!pe) evq.push_back('{cyc, lcd.lcd_rs, lcd.lcd_data});
        elen <= elen + 1;
      end else if (pe) begin
        chk("e_width", elen, EC);
        elen <= 0;
      end
      if (refresh_done) rd_cnt <= rd_cnt + 1;
      pe <= lcd.lcd_e;
    end
    prs <= lcd.lcd_rs;
    pd  <= lcd.lcd_data;
  end

  task automatic wait_cyc(input int n);
    int k = 0;
    while (cyc < n && k < 5000) begin @(negedge clk); #1; k++; end
  endtask

  task automatic pop_chk(input string tag, input logic rs, input logic [7:0] d, input int ecyc);
    ev_t ev;
    int  k = 0;
    while (evq.size() == 0 && k < 2000) begin @(negedge clk); #1; k++; end
    if (evq.size() == 0) begin
      chk({tag, "_timeout"}, evq.size(), 1);
    end else begin
      ev = evq.pop_front();
      chk({tag, "_rs"}, {31'd0, ev.rs}, {31'd0, rs});
      chk({tag, "_data"}, {24'd0, ev.data}, {24'd0, d});
      if (ecyc >= 0) chk({tag, "_cyc"}, ev.cyc, ecyc);
    end
  endtask

  task automatic chk_refresh(input string tag, input logic [127:0] a, input logic [127:0] b,
                             input int cyc80);
    pop_chk({tag, "_addr1"}, 1'b0, 8'h80, cyc80);
    for (int i = 0; i < 16; i++) pop_chk({tag, "_row1"}, 1'b1, ch(a, i), -1);
    pop_chk({tag, "_addr2"}, 1'b0, 8'hC0, -1);
    for (int i = 0; i < 16; i++) pop_chk({tag, "_row2"}, 1'b1, ch(b, i), -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] press, game, spaces;
    int base, k;
    press  = "PRESS * TO START";
    game   = "GAME OVER       ";
    spaces = {16{8'h20}};
    line1  = press;
    line2  = spaces;

    // reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_e", {31'd0, lcd.lcd_e}, 32'd0);
    chk("rst_rs", {31'd0, lcd.lcd_rs}, 32'd0);
    chk("rst_data", {24'd0, lcd.lcd_data}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdone", {31'd0, refresh_done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // power-up silence then init commands, 6 cycles apart
    wait_cyc(19);
    chk("pwrup_data", {24'd0, lcd.lcd_data}, 32'd0);
    pop_chk("init0", 1'b0, 8'h38, 21);
    pop_chk("init1", 1'b0, 8'h0C, 27);
    pop_chk("init2", 1'b0, 8'h06, 33);
    pop_chk("init3", 1'b0, 8'h01, 39);
    wait_cyc(50);
    chk("ready_pre", {31'd0, ready}, 32'd0);
    wait_cyc(51);
    chk("ready_rise", {31'd0, ready}, 32'd1);

    // refresh 1; line1 changes mid row 1 and must not leak in
    pop_chk("r1_addr1", 1'b0, 8'h80, 53);
    pop_chk("r1_c0", 1'b1, 8'h50, 59);
    pop_chk("r1_c1", 1'b1, 8'h52, -1);
    pop_chk("r1_c2", 1'b1, 8'h45, -1);
    pop_chk("r1_c3", 1'b1, 8'h53, -1);
    line1 = game;
    for (int i = 4; i < 15; i++) pop_chk("r1_row1", 1'b1, ch(press, i), -1);
    pop_chk("r1_c15", 1'b1, 8'h54, -1);
    pop_chk("r1_addr2", 1'b0, 8'hC0, -1);
    for (int i = 0; i < 16; i++) pop_chk("r1_row2", 1'b1, 8'h20, -1);
    wait_cyc(255);
    chk("rdone_pre", {31'd0, refresh_done}, 32'd0);
    wait_cyc(256);
    chk("rdone_pulse", {31'd0, refresh_done}, 32'd1);
    wait_cyc(257);
    chk("rdone_post", {31'd0, refresh_done}, 32'd0);
    chk("rdone_count", rd_cnt, 1);

    // refresh 2 picks up the new text
    pop_chk("r2_addr1", 1'b0, 8'h80, 259);
    pop_chk("r2_c0", 1'b1, 8'h47, -1);
    pop_chk("r2_c1", 1'b1, 8'h41, -1);
    pop_chk("r2_c2", 1'b1, 8'h4D, -1);
    pop_chk("r2_c3", 1'b1, 8'h45, -1);
    for (int i = 4; i < 16; i++) pop_chk("r2_row1", 1'b1, ch(game, i), -1);
    pop_chk("r2_addr2", 1'b0, 8'hC0, -1);
    for (int i = 0; i < 3; i++) pop_chk("r2_row2", 1'b1, 8'h20, -1);

    // reset while the strobe is high in row 2
    k = 0;
    while (!lcd.lcd_e && k < 50) begin @(negedge clk); #1; k++; end
    chk("mid_e_high", {31'd0, lcd.lcd_e}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_e", {31'd0, lcd.lcd_e}, 32'd0);
    chk("rst_async_ready", {31'd0, ready}, 32'd0);
    repeat (3) @(negedge clk);
    evq.delete();
    base = rd_cnt;
    rst = 1'b1;
    pop_chk("re_init0", 1'b0, 8'h38, 21);
    pop_chk("re_init1", 1'b0, 8'h0C, 27);
    pop_chk("re_init2", 1'b0, 8'h06, 33);
    pop_chk("re_init3", 1'b0, 8'h01, 39);
    chk_refresh("re_r1", game, spaces, 53);
    wait_cyc(258);
    chk("re_rdone_count", rd_cnt, base + 1);

`ifdef LCD_SKIP_UNCHANGED_EN
    // unchanged lines: no further bus activity and no refresh_done
    repeat (500) @(negedge clk);
    #1;
    chk("skip_quiet_bus", evq.size(), 0);
    chk("skip_quiet_rdone", rd_cnt, base + 1);
    line2[7:0] = 8'h31;
    chk_refresh("skip_r2", game, line2, -1);
    wait_cyc(cyc + 8);
    chk("skip_rdone_count", rd_cnt, base + 2);
`else
    // refreshes continue back to back
    chk_refresh("re_r2", game, spaces, 259);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
